// File: rtl/regfile_sb_if.sv
// Register file bus: read ports, write-back port, scoreboard issue port and status.
// The master drives addresses and write-back; the slave returns read data and status.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic [AW:0]         pend_cnt;
  logic                init_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    input  rd_data, rd_busy, pend_cnt, init_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    output rd_data, rd_busy, pend_cnt, init_done
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a per-register busy scoreboard.
// After reset an INIT sweep zeroes every entry before traffic is accepted.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_sb_if.slave bus
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   PEND_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [AW:0]       pend_cnt_q, pend_cnt_d;
  logic              init_done_q, init_done_d;
  logic [XLEN-1:0]   mem_q [NREG];

  logic              mem_we_s;
  logic [AW-1:0]     mem_waddr_s;
  logic [XLEN-1:0]   mem_wdata_s;
  logic              set_new_s;
  logic              clr_old_s;

  // FSM next state and storage write selection (INIT sweep or RUN write-back)
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    mem_wdata_s = '0;
    case (state_q)
      ST_INIT: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_cnt_q;
        clr_cnt_d   = clr_cnt_q + CNT_ONE;
        if (clr_cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        if (bus.wr_en && (bus.wr_addr != '0)) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = bus.wr_addr;
          mem_wdata_s = bus.wr_data;
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      default: begin
        state_d   = ST_INIT;
        clr_cnt_d = '0;
      end
    endcase
    init_done_d = (state_d == ST_RUN);
  end

  // Scoreboard update: write-back clears, issue sets and wins on the same address
  always_comb begin
    busy_d     = busy_q;
    pend_cnt_d = pend_cnt_q;
    set_new_s  = 1'b0;
    clr_old_s  = 1'b0;
    if (state_q == ST_RUN) begin
      if (bus.wr_en) begin
        busy_d[bus.wr_addr] = 1'b0;
      end else begin
        busy_d = busy_q;
      end
      if (bus.sb_set && (bus.sb_addr != '0)) begin
        busy_d[bus.sb_addr] = 1'b1;
      end else begin
        busy_d[0] = 1'b0;
      end
      set_new_s = bus.sb_set && (bus.sb_addr != '0) && !busy_q[bus.sb_addr];
      clr_old_s = bus.wr_en && busy_q[bus.wr_addr] &&
                  !(bus.sb_set && (bus.sb_addr == bus.wr_addr));
    end else begin
      busy_d = busy_q;
    end
    case ({set_new_s, clr_old_s})
      2'b10:   pend_cnt_d = pend_cnt_q + PEND_ONE;
      2'b01:   pend_cnt_d = pend_cnt_q - PEND_ONE;
      default: pend_cnt_d = pend_cnt_q;
    endcase
  end

  // Control state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      busy_q      <= '0;
      pend_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      busy_q      <= busy_d;
      pend_cnt_q  <= pend_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage array; contents are only cleared by the INIT sweep
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra_s;
    logic            hit_s;
    logic [XLEN-1:0] data_s;
    logic            busy_s;

    assign ra_s  = bus.rd_addr[k*AW +: AW];
    assign hit_s = bus.wr_en && (bus.wr_addr == ra_s);

    // Read mux: zero during INIT and for r0, bypass on a same-cycle write-back
    always_comb begin
      if ((state_q != ST_RUN) || (ra_s == '0)) begin
        data_s = '0;
        busy_s = 1'b0;
      end else if (hit_s) begin
        data_s = bus.wr_data;
        busy_s = 1'b0;
      end else begin
        data_s = mem_q[ra_s];
        busy_s = busy_q[ra_s];
      end
    end

    assign bus.rd_data[k*XLEN +: XLEN] = data_s;
    assign bus.rd_busy[k]              = busy_s;
  end

  assign bus.pend_cnt  = pend_cnt_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n;
  logic rst_b_n;

  regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) ifa ();
  regfile_sb_if #(.XLEN(64), .NREG(16), .NRD(3)) ifb ();

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2)) u_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (ifa.slave)
  );

  regfile_sb #(.XLEN(64), .NREG(16), .NRD(3)) u_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (ifb.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  busy;
    logic [5:0]  pend;
    logic        done;
  } exp_a_t;

  typedef struct {
    logic [191:0] data;
    logic [2:0]   busy;
    logic [4:0]   pend;
    logic         done;
  } exp_b_t;

  exp_a_t q_a[$];
  exp_b_t q_b[$];

  // Reference model: architectural register values, busy flags, cycles since reset release
  logic [31:0] ma_reg [32];
  bit          ma_busy [32];
  int          ma_cyc;
  logic [63:0] mb_reg [16];
  int          mb_cyc;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      exp_a_t e;
      e = q_a.pop_front();
      chk("a_rd_data",   192'(ifa.rd_data),   192'(e.data));
      chk("a_rd_busy",   192'(ifa.rd_busy),   192'(e.busy));
      chk("a_pend_cnt",  192'(ifa.pend_cnt),  192'(e.pend));
      chk("a_init_done", 192'(ifa.init_done), 192'(e.done));
    end
  end

  always @(negedge clk) begin
    if (q_b.size() > 0) begin
      exp_b_t e;
      e = q_b.pop_front();
      chk("b_rd_data",   192'(ifb.rd_data),   e.data);
      chk("b_rd_busy",   192'(ifb.rd_busy),   192'(e.busy));
      chk("b_pend_cnt",  192'(ifb.pend_cnt),  192'(e.pend));
      chk("b_init_done", 192'(ifb.init_done), 192'(e.done));
    end
  end

  // One cycle on DUT A: drive, predict, then advance the model to the next edge
  task automatic step_a(input bit we, input int wa, input logic [31:0] wd,
                        input bit ss, input int sa, input int r0, input int r1);
    exp_a_t e;
    int     ra[2];
    int     cnt;
    ifa.wr_en   = we;
    ifa.wr_addr = wa[4:0];
    ifa.wr_data = wd;
    ifa.sb_set  = ss;
    ifa.sb_addr = sa[4:0];
    ifa.rd_addr = {r1[4:0], r0[4:0]};
    ra[0] = r0;
    ra[1] = r1;
    e.data = '0;
    e.busy = '0;
    for (int k = 0; k < 2; k++) begin
      if (ma_cyc >= 32 && ra[k] != 0) begin
        if (we && wa == ra[k]) begin
          e.data[k*32 +: 32] = wd;
        end else begin
          e.data[k*32 +: 32] = ma_reg[ra[k]];
          e.busy[k]          = ma_busy[ra[k]];
        end
      end
    end
    cnt = 0;
    for (int i = 0; i < 32; i++) cnt += int'(ma_busy[i]);
    e.pend = cnt[5:0];
    e.done = (ma_cyc >= 32);
    q_a.push_back(e);
    if (ma_cyc >= 32) begin
      if (we && wa != 0) ma_reg[wa] = wd;
      if (we) ma_busy[wa] = 1'b0;
      if (ss && sa != 0) ma_busy[sa] = 1'b1;
    end
    ma_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input bit we, input int wa, input logic [63:0] wd,
                        input int r0, input int r1, input int r2);
    exp_b_t e;
    int     ra[3];
    ifb.wr_en   = we;
    ifb.wr_addr = wa[3:0];
    ifb.wr_data = wd;
    ifb.sb_set  = 1'b0;
    ifb.sb_addr = '0;
    ifb.rd_addr = {r2[3:0], r1[3:0], r0[3:0]};
    ra[0] = r0;
    ra[1] = r1;
    ra[2] = r2;
    e.data = '0;
    e.busy = '0;
    e.pend = '0;
    for (int k = 0; k < 3; k++) begin
      if (mb_cyc >= 16 && ra[k] != 0) begin
        if (we && wa == ra[k]) e.data[k*64 +: 64] = wd;
        else                   e.data[k*64 +: 64] = mb_reg[ra[k]];
      end
    end
    e.done = (mb_cyc >= 16);
    q_b.push_back(e);
    if (mb_cyc >= 16 && we && wa != 0) mb_reg[wa] = wd;
    mb_cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse on DUT A, issued mid-cycle
  task automatic reset_a();
    rst_a_n     = 1'b0;
    ifa.wr_en   = 1'b0;
    ifa.sb_set  = 1'b0;
    #2;
    chk("a_rst_pend_cnt",  192'(ifa.pend_cnt),  192'(0));
    chk("a_rst_init_done", 192'(ifa.init_done), 192'(0));
    for (int i = 0; i < 32; i++) begin
      ma_busy[i] = 1'b0;
      ma_reg[i]  = 32'h0;
    end
    ma_cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_a_n = 1'b1;
  endtask

  task automatic rand_a_init_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step_a(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
             1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end
  endtask

  task automatic sweep_a();
    for (int i = 0; i < 16; i++) step_a(1'b0, 0, 32'h0, 1'b0, 0, 2*i, 2*i + 1);
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifa.sb_set = 1'b0; ifa.sb_addr = '0; ifa.rd_addr = '0;
    ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0;
    ifb.sb_set = 1'b0; ifb.sb_addr = '0; ifb.rd_addr = '0;
    for (int i = 0; i < 32; i++) begin
      ma_reg[i]  = 32'h0;
      ma_busy[i] = 1'b0;
    end
    for (int i = 0; i < 16; i++) mb_reg[i] = 64'h0;
    ma_cyc = 0;
    mb_cyc = 0;
    #3;
    chk("a_por_pend_cnt",  192'(ifa.pend_cnt),  192'(0));
    chk("a_por_init_done", 192'(ifa.init_done), 192'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_a_n = 1'b1;

    // INIT with random traffic that must be ignored; init_done rises on cycle 32
    rand_a_init_cycles(34);
    sweep_a();

    // Bypass then storage
    step_a(1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 5, 5);
    step_a(1'b0, 0, 32'h0, 1'b0, 0, 5, 0);

    // Register 0 is immune to writes and issue
    step_a(1'b1, 0, 32'h1234_5678, 1'b1, 0, 0, 0);
    step_a(1'b0, 0, 32'h0, 1'b0, 0, 0, 0);

    // Scoreboard sequence: issue 3,7,7; retire 3; retire 7 colliding with re-issue of 7
    step_a(1'b0, 0, 32'h0, 1'b1, 3, 3, 7);
    step_a(1'b0, 0, 32'h0, 1'b1, 7, 3, 7);
    step_a(1'b0, 0, 32'h0, 1'b1, 7, 3, 7);
    step_a(1'b0, 0, 32'h0, 1'b0, 0, 3, 7);
    step_a(1'b1, 3, 32'hA5A5_0003, 1'b0, 0, 3, 7);
    step_a(1'b1, 7, 32'hA5A5_0007, 1'b1, 7, 7, 3);
    step_a(1'b0, 0, 32'h0, 1'b0, 0, 7, 3);

    // Randomised traffic, mostly on a small address window to force collisions
    for (int i = 0; i < 400; i++) begin
      int wa;
      int sa;
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      step_a(1'($urandom_range(0, 1)), wa, $urandom, ($urandom_range(0, 9) < 4), sa,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
    end

    // Reset mid-run with registers 3 and 9 busy and storage full of data
    for (int i = 1; i < 32; i++) step_a(1'b1, i, $urandom | 32'h1, 1'b0, 0, i, 0);
    step_a(1'b0, 0, 32'h0, 1'b1, 3, 3, 9);
    step_a(1'b0, 0, 32'h0, 1'b1, 9, 3, 9);
    step_a(1'b0, 0, 32'h0, 1'b0, 0, 3, 9);
    reset_a();
    rand_a_init_cycles(33);
    sweep_a();

    // Wide, three-port instance
    rst_b_n = 1'b1;
    for (int i = 0; i < 17; i++) step_b(1'b1, i % 16, {$urandom, $urandom}, 1, 15, 0);
    step_b(1'b1, 1, 64'hFEDC_BA98_7654_3210, 1, 1, 15);
    step_b(1'b1, 15, 64'h0123_4567_89AB_CDEF, 1, 1, 15);
    step_b(1'b0, 0, 64'h0, 1, 1, 15);
    for (int i = 0; i < 20; i++) begin
      step_b(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), {$urandom, $urandom},
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
